// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared constants and FSM state type for the sensor alarm block
package sensor_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_WIDTH_DEF       = 8;
  localparam int SENSOR_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_ALARM   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/sensor_alarm_if.sv
// rtl/sensor_alarm_if.sv - sensor/ack inputs and alarm status outputs of the alarm block
interface sensor_alarm_if #(
  parameter int CNT_WIDTH = sensor_pkg::CNT_WIDTH_DEF
);
  import sensor_pkg::*;

  logic [SENSOR_W-1:0]  sensors;
  logic                 ack;
  logic                 alarm;
  logic [SENSOR_W-1:0]  alarm_src;
  logic                 armed;
  logic [CNT_WIDTH-1:0] err_count;

  // Host side: drives raw sensors and acknowledge, observes status
  modport master (
    output sensors,
    output ack,
    input  alarm,
    input  alarm_src,
    input  armed,
    input  err_count
  );

  // Alarm block side
  modport slave (
    input  sensors,
    input  ack,
    output alarm,
    output alarm_src,
    output armed,
    output err_count
  );

endinterface

// File: rtl/sensor_b.sv
// rtl/sensor_b.sv - combinational error-condition decode of the sampled sensor vector
module sensor_b
  import sensor_pkg::*;
(
  input  logic [SENSOR_W-1:0] i_sens,
  output logic                o_cond
);

  // Sensor 0 alone is fatal; sensor 1 only counts together with sensor 2 or 3
  assign o_cond = i_sens[0] | (i_sens[1] & (i_sens[2] | i_sens[3]));

endmodule

// File: rtl/sensor_alarm.sv
// rtl/sensor_alarm.sv - debounced sensor alarm with acknowledge, re-arm hold and event counter
module sensor_alarm
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sensor_alarm_if.slave bus
);

  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [QW-1:0] QUAL_LAST = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [QW-1:0] QUAL_ONE  = QW'(1);

  logic [SENSOR_W-1:0]  r_sens_q;
  logic                 w_cond;
  state_t               r_state;
  state_t               w_state_next;
  logic [QW-1:0]        r_qual_cnt;
  logic [QW-1:0]        w_qual_next;
  logic                 w_alarm_event;
  logic                 w_alarm_d;
  logic                 w_armed_d;
  logic                 r_alarm;
  logic                 r_armed;
  logic [SENSOR_W-1:0]  r_alarm_src;
  logic [CNT_WIDTH-1:0] r_err_count;

  // Register the raw sensors once; every decision below looks only at this copy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sens_q <= '0;
    end else begin
      r_sens_q <= bus.sensors;
    end
  end

  sensor_b u_cond (
    .i_sens (r_sens_q),
    .o_cond (w_cond)
  );

  // State and debounce counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_qual_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_qual_cnt <= w_qual_next;
    end
  end

  // Next-state and debounce counter decode
  always_comb begin
    w_state_next = r_state;
    w_qual_next  = r_qual_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_cond) begin
          w_state_next = ST_QUALIFY;
          w_qual_next  = QUAL_ONE;
        end
      end
      ST_QUALIFY: begin
        if (!w_cond) begin
          w_state_next = ST_IDLE;
          w_qual_next  = '0;
        end else if (r_qual_cnt == QUAL_LAST) begin
          w_state_next = ST_ALARM;
          w_qual_next  = '0;
        end else begin
          w_qual_next  = r_qual_cnt + QUAL_ONE;
        end
      end
      ST_ALARM: begin
        // Acknowledge with the fault still present parks in HOLD so the
        // alarm cannot retrigger until the sensors have been seen clear.
        if (bus.ack) begin
          w_state_next = w_cond ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!w_cond) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_qual_next  = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the flags register in step with it
  always_comb begin
    w_alarm_event = (r_state == ST_QUALIFY) && (w_state_next == ST_ALARM);
    w_alarm_d     = (w_state_next == ST_ALARM);
    w_armed_d     = (w_state_next == ST_IDLE) || (w_state_next == ST_QUALIFY);
  end

  // Registered status flags, source snapshot and saturating event counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm     <= 1'b0;
      r_armed     <= 1'b1;
      r_alarm_src <= '0;
      r_err_count <= '0;
    end else begin
      r_alarm <= w_alarm_d;
      r_armed <= w_armed_d;
      if (w_alarm_event) begin
        r_alarm_src <= r_sens_q;
        if (r_err_count != {CNT_WIDTH{1'b1}}) begin
          r_err_count <= r_err_count + 1'b1;
        end
      end
    end
  end

  assign bus.alarm     = r_alarm;
  assign bus.armed     = r_armed;
  assign bus.alarm_src = r_alarm_src;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_sensor_alarm.sv
// tb/tb_sensor_alarm.sv - directed self-checking bench for sensor_alarm
module tb_sensor_alarm;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sensor_alarm_if #(.CNT_WIDTH(8)) bus ();

  sensor_alarm #(
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.sensors = 4'b0000;
    bus.ack     = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic raise_event(input logic [3:0] s);
    int n;
    bus.sensors = s;
    n = 0;
    while (!bus.alarm && n < 10) begin
      tick();
      n++;
    end
    check("ev_latency", n, 5);
  endtask

  task automatic clear_event();
    bus.sensors = 4'b0000;
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  initial begin
    logic seen;
    n_cmp = 0;
    n_err = 0;
    rst         = 1'b1;
    bus.sensors = 4'b0000;
    bus.ack     = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    check("rst_alarm", bus.alarm, 1'b0);
    check("rst_src", bus.alarm_src, 4'h0);
    check("rst_armed", bus.armed, 1'b1);
    check("rst_err", bus.err_count, 8'h00);

    // three sampled cycles of a valid condition must not alarm
    bus.sensors = 4'b0110;
    repeat (3) tick();
    check("short_armed", bus.armed, 1'b1);
    bus.sensors = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | bus.alarm;
    end
    check("short_alarm", seen, 1'b0);
    check("short_err", bus.err_count, 8'h00);
    check("short_armed2", bus.armed, 1'b1);

    // held condition: alarm on edge 5
    bus.sensors = 4'b0001;
    repeat (4) tick();
    check("lat_e4_alarm", bus.alarm, 1'b0);
    check("lat_e4_armed", bus.armed, 1'b1);
    tick();
    check("lat_e5_alarm", bus.alarm, 1'b1);
    check("lat_e5_src", bus.alarm_src, 4'b0001);
    check("lat_e5_err", bus.err_count, 8'h01);
    check("lat_e5_armed", bus.armed, 1'b0);

    // ack with sensors clear returns to IDLE
    bus.sensors = 4'b0000;
    tick();
    check("noack_alarm", bus.alarm, 1'b1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("ack_alarm", bus.alarm, 1'b0);
    check("ack_armed", bus.armed, 1'b1);
    check("ack_src_hold", bus.alarm_src, 4'b0001);
    bus.ack = 1'b1;
    repeat (2) tick();
    bus.ack = 1'b0;
    check("idle_ack_alarm", bus.alarm, 1'b0);
    check("idle_ack_armed", bus.armed, 1'b1);
    check("idle_ack_err", bus.err_count, 8'h01);

    // ack while fault present goes to HOLD, re-alarm needs clear first
    do_reset();
    bus.sensors = 4'b1010;
    repeat (5) tick();
    check("hold_a1_alarm", bus.alarm, 1'b1);
    check("hold_a1_err", bus.err_count, 8'h01);
    check("hold_a1_src", bus.alarm_src, 4'b1010);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("hold_alarm", bus.alarm, 1'b0);
    check("hold_armed", bus.armed, 1'b0);
    repeat (6) tick();
    check("hold_stay_alarm", bus.alarm, 1'b0);
    check("hold_stay_armed", bus.armed, 1'b0);
    check("hold_stay_err", bus.err_count, 8'h01);
    bus.sensors = 4'b0000;
    repeat (2) tick();
    check("hold_exit_armed", bus.armed, 1'b1);
    bus.sensors = 4'b1010;
    repeat (5) tick();
    check("hold_a2_alarm", bus.alarm, 1'b1);
    check("hold_a2_err", bus.err_count, 8'h02);

    // reset mid-QUALIFY and in ALARM restarts the full debounce
    do_reset();
    bus.sensors = 4'b0001;
    repeat (4) tick();
    check("q3_alarm", bus.alarm, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rq_alarm", bus.alarm, 1'b0);
    check("rq_armed", bus.armed, 1'b1);
    check("rq_err", bus.err_count, 8'h00);
    repeat (4) tick();
    check("rq_e4_alarm", bus.alarm, 1'b0);
    tick();
    check("rq_e5_alarm", bus.alarm, 1'b1);
    check("rq_e5_err", bus.err_count, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ra_alarm", bus.alarm, 1'b0);
    check("ra_src", bus.alarm_src, 4'h0);
    check("ra_armed", bus.armed, 1'b1);
    check("ra_err", bus.err_count, 8'h00);
    repeat (4) tick();
    check("ra_e4_alarm", bus.alarm, 1'b0);
    tick();
    check("ra_e5_alarm", bus.alarm, 1'b1);

    // counter saturation
    do_reset();
    for (int i = 0; i < 255; i++) begin
      raise_event(i[0] ? 4'b0110 : 4'b0001);
      clear_event();
      if (i == 253) check("err_254", bus.err_count, 8'hFE);
    end
    check("err_255", bus.err_count, 8'hFF);
    raise_event(4'b1010);
    check("sat_alarm", bus.alarm, 1'b1);
    check("sat_err", bus.err_count, 8'hFF);
    check("sat_src", bus.alarm_src, 4'b1010);
    clear_event();
    check("sat_clear_alarm", bus.alarm, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
